// File: rtl/digit_seq_pkg.sv
// Shared state encodings, digit constants and transition functions for the
// forward (2,1,2,7,8) and reverse (8,7,2,1,2) digit-sequence detectors.
package digit_seq_pkg;

    localparam logic [3:0] D1 = 4'd1;
    localparam logic [3:0] D2 = 4'd2;
    localparam logic [3:0] D7 = 4'd7;
    localparam logic [3:0] D8 = 4'd8;

    typedef enum logic [2:0] {F0, F1, F2, F3, F4} fwd_state_t;
    typedef enum logic [2:0] {R0, R1, R2, R3, R4} rev_state_t;

    // Digits outside {1,2,7,8} fall through to the F0 default.
    function automatic fwd_state_t fwd_next(input fwd_state_t s, input logic [3:0] d);
        fwd_state_t n;
        n = F0;
        case (s)
            F0: if (d == D2) n = F1;
            F1: if (d == D1) n = F2; else if (d == D2) n = F1;
            F2: if (d == D2) n = F3;
            F3: if (d == D7) n = F4; else if (d == D1) n = F2; else if (d == D2) n = F1;
            F4: if (d == D2) n = F1;
            default: n = F0;
        endcase
        return n;
    endfunction

    function automatic rev_state_t rev_next(input rev_state_t s, input logic [3:0] d);
        rev_state_t n;
        n = R0;
        case (s)
            R0: if (d == D8) n = R1;
            R1: if (d == D7) n = R2; else if (d == D8) n = R1;
            R2: if (d == D2) n = R3; else if (d == D8) n = R1;
            R3: if (d == D1) n = R4; else if (d == D8) n = R1;
            R4: if (d == D8) n = R1;
            default: n = R0;
        endcase
        return n;
    endfunction

    // True on the valid digit that completes a sequence from the last state.
    function automatic logic final_hit(input bit rev, input logic [2:0] st,
                                       input logic [3:0] d, input logic vld);
        return vld && (st == 3'd4) && (d == (rev ? D2 : D8));
    endfunction

endpackage

// File: rtl/digit_seq_detector_if.sv
// Digit stream in, match pulses / counter / progress out.
interface digit_seq_detector_if #(parameter int CNT_W = 8);
    logic [3:0]       in;
    logic             in_valid;
    logic             clr_cnt;
    logic             match_fwd;
    logic             match_rev;
    logic [CNT_W-1:0] match_cnt;
    logic [2:0]       progress;

    modport master (output in, in_valid, clr_cnt,
                    input  match_fwd, match_rev, match_cnt, progress);
    modport slave  (input  in, in_valid, clr_cnt,
                    output match_fwd, match_rev, match_cnt, progress);
endinterface

// File: rtl/digit_seq_detector_seq_step.sv
// One sequence detector FSM; REV selects the reverse (8,7,2,1,2) pattern.
// state is the registered match-depth index 0..4, match a one-cycle pulse.
module seq_step
    import digit_seq_pkg::*;
#(
    parameter bit REV = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       valid,
    output logic [2:0] state,
    output logic       match
);

    logic [2:0] nxt;

    always_comb begin
        nxt = state;
        if (REV) nxt = rev_next(rev_state_t'(state), digit);
        else     nxt = fwd_next(fwd_state_t'(state), digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 3'd0;
            match <= 1'b0;
        end else begin
            match <= final_hit(REV, state, digit, valid);
            if (valid) state <= nxt;
        end
    end

endmodule

// File: rtl/digit_seq_detector.sv
// Forward/reverse digit-sequence detector with saturating match counter.
// Build option: define DIGIT_SEQ_REV_EN to include the reverse detector.
module digit_seq_detector
    import digit_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    digit_seq_detector_if.slave bus
);

    logic [2:0]       fwd_state;
    logic             fwd_hit;
    logic             rev_hit;
    logic [CNT_W-1:0] cnt;

    seq_step #(.REV(1'b0)) u_fwd (
        .clk   (clk),
        .rst   (rst),
        .digit (bus.in),
        .valid (bus.in_valid),
        .state (fwd_state),
        .match (bus.match_fwd)
    );

    assign fwd_hit      = final_hit(1'b0, fwd_state, bus.in, bus.in_valid);
    assign bus.progress = fwd_state;

`ifdef DIGIT_SEQ_REV_EN
    logic [2:0] rev_state;

    seq_step #(.REV(1'b1)) u_rev (
        .clk   (clk),
        .rst   (rst),
        .digit (bus.in),
        .valid (bus.in_valid),
        .state (rev_state),
        .match (bus.match_rev)
    );

    assign rev_hit = final_hit(1'b1, rev_state, bus.in, bus.in_valid);
`else
    assign rev_hit       = 1'b0;
    assign bus.match_rev = 1'b0;
`endif

    // Counter moves on the same edge that launches the match pulse; the two
    // hits can never coincide because the final digits differ.
    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt)
            cnt <= '0;
        else if ((fwd_hit || rev_hit) && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    assign bus.match_cnt = cnt;

endmodule

// File: doc/digit_seq_detector.md
DIGIT_SEQ_DETECTOR -- requirements
Module: digit_seq_detector

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, meaning the width of the saturating match counter.
REQ-002 The module SHALL have port clk, input, 1, the sole clock; all logic is updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port in, input, 4, the digit sampled from the upstream digit-sequence FSM.
REQ-005 The module SHALL have port in_valid, input, 1; in is sampled only when in_valid is high.
REQ-006 The module SHALL have port clr_cnt, input, 1, synchronous clear of match_cnt.
REQ-007 The module SHALL have port match_fwd, output, 1, a one-cycle pulse on a completed forward sequence.
REQ-008 The module SHALL have port match_rev, output, 1, a one-cycle pulse on a completed reverse sequence.
REQ-009 The module SHALL have port match_cnt, output, CNT_W, the saturating count of completed sequences.
REQ-010 The module SHALL have port progress, output, 3, the forward-detector state index (0-4).

Function
REQ-011 The forward detector SHALL recognise the digits 2,1,2,7,8 in order, allowing overlaps, with states F0..F4 holding 0..4 matched digits.
REQ-012 The forward detector SHALL transition on a valid digit as follows: F0: 2->F1, else F0; F1: 1->F2, 2->F1, else F0; F2: 2->F3, else F0; F3: 7->F4, 1->F2, 2->F1, else F0; F4: 8->F0 with match, 2->F1, else F0.
REQ-013 The reverse detector SHALL recognise 8,7,2,1,2 using states R0..R4: R0: 8->R1, else R0; R1: 7->R2, 8->R1, else R0; R2: 2->R3, 8->R1, else R0; R3: 1->R4, 8->R1, else R0; R4: 2->R0 with match, 8->R1, else R0.
REQ-014 Digits outside {1,2,7,8} SHALL take the "else" transition.
REQ-015 When in_valid is low, both detectors and all outputs except the match pulses SHALL hold their values.
REQ-016 match_fwd and match_rev SHALL be registered and high for exactly the one cycle after the edge that samples the final digit; otherwise low.
REQ-017 match_fwd and match_rev SHALL never be high together (the final digits differ).
REQ-018 match_cnt SHALL increment by 1 per match pulse and saturate at 2^CNT_W-1 with no wrap.
REQ-019 When clr_cnt is high, match_cnt SHALL become 0 on that edge, overriding a simultaneous increment; detector states are unaffected.
REQ-020 progress SHALL equal the current forward state index, registered.
REQ-021 A continuous forward stream from the upstream FSM SHALL yield one match_fwd every 5 valid digits.

Reset
REQ-022 When rst is high on a rising edge, the module SHALL set both detectors to F0/R0, match_fwd=0, match_rev=0, match_cnt=0 and progress=0, overriding in_valid and clr_cnt.
REQ-023 A reset mid-sequence SHALL discard all partial progress; the next valid 2 SHALL be treated as a first digit.

Configuration
REQ-024 Macro DIGIT_SEQ_REV_EN SHALL control the reverse detector: when it is defined, the reverse detector is present and its matches count in match_cnt.
REQ-025 When DIGIT_SEQ_REV_EN is undefined, the module SHALL contain no reverse-detector logic, match_rev SHALL be tied to 0, and only forward matches SHALL count.

Structure
REQ-026 Package digit_seq_pkg SHALL hold the forward/reverse state typedefs and the digit constants 1, 2, 7 and 8.
REQ-027 The forward/reverse detector step SHALL be one sub-module, seq_step, parameterised by direction and instantiated once or twice.

Verification
REQ-028 Reset then valid 2,1,2,7,8 SHALL give match_fwd=1 one cycle after the 8, match_cnt=1 and progress sequence 1,2,3,4,0.
REQ-029 Valid 2,1,2,1,2,7,8 SHALL give exactly one match_fwd (F3 on 1 goes to F2), with match_cnt=1.
REQ-030 With DIGIT_SEQ_REV_EN defined, 8,7,2,1,2,8,7,2,1,2 SHALL give two match_rev pulses and match_cnt=2; with it undefined, match_rev=0 and match_cnt=0.
REQ-031 Sequence 2,1 then in_valid=0 for 3 cycles then 2,7,8 SHALL give match_fwd once, with progress held at 2 during the gap.
REQ-032 A forward stream with CNT_W=2 SHALL saturate match_cnt at 3; clr_cnt coincident with the 4th match SHALL give match_cnt=0.
REQ-033 rst asserted after 2,1,2,7 followed by 8 SHALL give no match, with progress=0.
